// File: rtl/ldtu_packer_pkg.sv
// ldtu_packer_pkg
// Shared definitions for the LiTe-DTU sample packer: word header codes,
// trailer pattern, pack FSM state encoding and word formatting helpers.
// No ports (package).

package ldtu_packer_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BASE  = 2'd1,
    ST_SIG   = 2'd2
  } pack_state_e;

  localparam logic [1:0]  HDR_BASE5     = 2'b01;
  localparam logic [3:0]  HDR_BASEP     = 4'b1110;
  localparam logic [3:0]  HDR_SIG2      = 4'b0010;
  localparam logic [3:0]  HDR_SIG1      = 4'b0011;
  localparam logic [3:0]  HDR_TRAIL     = 4'b1101;
  localparam logic [15:0] TRAIL_PATTERN = 16'hA5A5;

  // Up to four held 6-bit baseline samples, entry 0 is the oldest.
  typedef logic [3:0][5:0] base_hold_t;

  function automatic logic [31:0] fmt_base5(input base_hold_t held, input logic [5:0] b4);
    return {HDR_BASE5, b4, held[3], held[2], held[1], held[0]};
  endfunction

  // Entries at or above cnt may hold stale data; they are forced to zero.
  function automatic logic [31:0] fmt_basep(input logic [2:0] cnt, input base_hold_t held);
    logic [23:0] payload;
    payload = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < cnt) payload[i*6 +: 6] = held[i];
    end
    return {HDR_BASEP, 1'b0, cnt, payload};
  endfunction

  function automatic logic [31:0] fmt_sig2(input logic [12:0] s1, input logic [12:0] s0);
    return {HDR_SIG2, 2'b00, s1, s0};
  endfunction

  function automatic logic [31:0] fmt_sig1(input logic [12:0] s0);
    return {HDR_SIG1, 15'b0, s0};
  endfunction

  function automatic logic [31:0] fmt_trailer(input logic [7:0] frame_cnt);
    return {HDR_TRAIL, 4'b0000, frame_cnt, TRAIL_PATTERN};
  endfunction

endpackage

// File: rtl/ldtu_word_fifo.sv
// ldtu_word_fifo
// 32-bit show-ahead synchronous FIFO. A push while full is accepted only
// when a pop happens in the same cycle; otherwise it is ignored and the
// caller is responsible for flagging the loss.
// Ports:
//   CLK, rst_b   clock, async active-low reset
//   push_i       write wdata_i this cycle
//   pop_i        discard the head word this cycle (ignored when empty)
//   wdata_i      word to write
//   rdata_o      head word, forced to 0 when empty
//   full_o       Depth words stored
//   empty_o      no words stored

module ldtu_word_fifo #(
  parameter int Depth = 4
) (
  input  logic        CLK,
  input  logic        rst_b,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [31:0]   mem_q [Depth];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(Depth));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = empty_o ? 32'h0 : mem_q[rd_ptr_q];

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ldtu_sample_packer.sv
// ldtu_sample_packer
// Packs the input-FIFO sample stream into 32-bit words (BASE5/BASEP for
// baseline samples, SIG2/SIG1 for signal samples) and queues them in a
// small output FIFO towards the serializer.
// Optional frame trailers are built when LDTU_PACKER_FRAME_EN is defined.
// Ports:
//   CLK, rst_b     clock, async active-low reset
//   sample_valid   DATA_in/baseline_flag valid this cycle
//   DATA_in        [12] gain flag, [11:0] sample
//   baseline_flag  1: baseline sample, only DATA_in[5:0] is used
//   flush          emit held samples as a partial word
//   word_ready     downstream accepts word_data
//   word_valid     word_data holds a valid word
//   word_data      packed word
//   fifo_ovf       sticky, a word was dropped on a full output FIFO
//
// state    | meaning
// ST_EMPTY | nothing held
// ST_BASE  | bcnt (1..4) baseline samples held
// ST_SIG   | one signal sample held

module ldtu_sample_packer
  import ldtu_packer_pkg::*;
#(
  parameter int OutFifoDepth = 4
`ifdef LDTU_PACKER_FRAME_EN
  , parameter int FrameLen = 64
`endif
) (
  input  logic        CLK,
  input  logic        rst_b,
  input  logic        sample_valid,
  input  logic [12:0] DATA_in,
  input  logic        baseline_flag,
  input  logic        flush,
  input  logic        word_ready,
  output logic        word_valid,
  output logic [31:0] word_data,
  output logic        fifo_ovf
);

  pack_state_e st_q, st_d;
  logic [2:0]  bcnt_q, bcnt_d;
  base_hold_t  base_q, base_d;
  logic [12:0] sig_q, sig_d;
  logic        flush_pend_q, flush_pend_d;
  logic        data_push;
  logic [31:0] data_word;

  logic        push, pop, fifo_full, fifo_empty;
  logic [31:0] push_word;
  logic        ovf_q;

  always_comb begin
    st_d         = st_q;
    bcnt_d       = bcnt_q;
    base_d       = base_q;
    sig_d        = sig_q;
    flush_pend_d = 1'b0;
    data_push    = 1'b0;
    data_word    = 32'h0;

    if (sample_valid) begin
      case (st_q)
        ST_EMPTY: begin
          if (baseline_flag) begin
            base_d[0] = DATA_in[5:0];
            bcnt_d    = 3'd1;
            st_d      = ST_BASE;
          end else begin
            sig_d = DATA_in;
            st_d  = ST_SIG;
          end
        end
        ST_BASE: begin
          if (baseline_flag) begin
            if (bcnt_q == 3'd4) begin
              data_push = 1'b1;
              data_word = fmt_base5(base_q, DATA_in[5:0]);
              bcnt_d    = 3'd0;
              st_d      = ST_EMPTY;
            end else begin
              base_d[bcnt_q[1:0]] = DATA_in[5:0];
              bcnt_d              = bcnt_q + 3'd1;
            end
          end else begin
            data_push = 1'b1;
            data_word = fmt_basep(bcnt_q, base_q);
            bcnt_d    = 3'd0;
            sig_d     = DATA_in;
            st_d      = ST_SIG;
          end
        end
        ST_SIG: begin
          data_push = 1'b1;
          if (baseline_flag) begin
            data_word = fmt_sig1(sig_q);
            base_d[0] = DATA_in[5:0];
            bcnt_d    = 3'd1;
            st_d      = ST_BASE;
          end else begin
            data_word = fmt_sig2(DATA_in, sig_q);
            st_d      = ST_EMPTY;
          end
        end
        default: st_d = ST_EMPTY;
      endcase
    end

    // Flush acts on what is held after the sample was absorbed. If that
    // sample already produced a word, the flush waits one cycle.
    if ((flush | flush_pend_q) && (st_d != ST_EMPTY)) begin
      if (!data_push) begin
        data_push = 1'b1;
        data_word = (st_d == ST_SIG) ? fmt_sig1(sig_d) : fmt_basep(bcnt_d, base_d);
        bcnt_d    = 3'd0;
        st_d      = ST_EMPTY;
      end else begin
        flush_pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      st_q         <= ST_EMPTY;
      bcnt_q       <= 3'd0;
      base_q       <= '0;
      sig_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      st_q         <= st_d;
      bcnt_q       <= bcnt_d;
      base_q       <= base_d;
      sig_q        <= sig_d;
      flush_pend_q <= flush_pend_d;
    end
  end

`ifdef LDTU_PACKER_FRAME_EN
  localparam int DCW = (FrameLen > 1) ? $clog2(FrameLen) : 1;

  logic [DCW-1:0] dcnt_q;
  logic           trail_pend_q;
  logic [7:0]     frame_cnt_q;
  logic           trail_push;

  // Trailer only takes a cycle that carries no data word.
  assign trail_push = trail_pend_q & ~data_push;
  assign push       = data_push | trail_push;
  assign push_word  = data_push ? data_word : fmt_trailer(frame_cnt_q);

  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      dcnt_q       <= '0;
      trail_pend_q <= 1'b0;
      frame_cnt_q  <= 8'd0;
    end else if (data_push) begin
      if (dcnt_q == DCW'(FrameLen - 1)) begin
        dcnt_q       <= '0;
        trail_pend_q <= 1'b1;
      end else begin
        dcnt_q <= dcnt_q + 1'b1;
      end
    end else if (trail_push) begin
      trail_pend_q <= 1'b0;
      frame_cnt_q  <= frame_cnt_q + 8'd1;
    end
  end
`else
  assign push      = data_push;
  assign push_word = data_word;
`endif

  assign pop = word_valid & word_ready;

  ldtu_word_fifo #(
    .Depth (OutFifoDepth)
  ) u_word_fifo (
    .CLK     (CLK),
    .rst_b   (rst_b),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_word),
    .rdata_o (word_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign word_valid = ~fifo_empty;

  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) ovf_q <= 1'b0;
    else if (push & fifo_full & ~pop) ovf_q <= 1'b1;
  end

  assign fifo_ovf = ovf_q;

endmodule

// File: tb/tb_ldtu_sample_packer.sv
module tb_ldtu_sample_packer;

  localparam int DEPTH = 4;
  localparam int FL    = 2;

  logic        CLK = 1'b0;
  logic        rst_b = 1'b0;
  logic        sample_valid = 1'b0;
  logic [12:0] DATA_in = '0;
  logic        baseline_flag = 1'b0;
  logic        flush = 1'b0;
  logic        word_ready = 1'b0;
  logic        word_valid;
  logic [31:0] word_data;
  logic        fifo_ovf;

  always #5 CLK = ~CLK;

  ldtu_sample_packer #(
    .OutFifoDepth (DEPTH)
`ifdef LDTU_PACKER_FRAME_EN
    , .FrameLen   (FL)
`endif
  ) dut (
    .CLK           (CLK),
    .rst_b         (rst_b),
    .sample_valid  (sample_valid),
    .DATA_in       (DATA_in),
    .baseline_flag (baseline_flag),
    .flush         (flush),
    .word_ready    (word_ready),
    .word_valid    (word_valid),
    .word_data     (word_data),
    .fifo_ovf      (fifo_ovf)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  // ---------------- word builders (plain arithmetic) ----------------
  function automatic logic [31:0] w_sig2(input logic [31:0] s1, input logic [31:0] s0);
    return 32'h2000_0000 | (s1 << 13) | s0;
  endfunction
  function automatic logic [31:0] w_sig1(input logic [31:0] s0);
    return 32'h3000_0000 | s0;
  endfunction
  function automatic logic [31:0] w_base5(input logic [31:0] q[$]);
    logic [31:0] w = 32'h4000_0000;
    for (int i = 0; i < q.size(); i++) w |= q[i] << (6 * i);
    return w;
  endfunction
  function automatic logic [31:0] w_basep(input logic [31:0] q[$]);
    logic [31:0] w = 32'hE000_0000 | (32'(q.size()) << 24);
    for (int i = 0; i < q.size(); i++) w |= q[i] << (6 * i);
    return w;
  endfunction
  function automatic logic [31:0] w_trail(input logic [31:0] fc);
    return 32'hD000_0000 | (fc << 16) | 32'h0000_A5A5;
  endfunction

  // ---------------- behavioural reference model ----------------
  logic [31:0] mb[$];      // held baseline values, oldest first
  bit          ms_held;
  logic [31:0] ms;
  bit          m_pend;
  logic [31:0] mq[$];      // output FIFO contents
  bit          m_ovf;
  int          m_dcnt, m_fcnt;
  bit          m_tpend;
  bit          use_model = 0;

  task automatic model_clear();
    mb.delete(); mq.delete();
    ms_held = 0; ms = 0; m_pend = 0; m_ovf = 0;
    m_dcnt = 0; m_fcnt = 0; m_tpend = 0;
  endtask

  task automatic model_cycle(input bit sv, input logic [12:0] din, input bit bf,
                             input bit fl, input bit rdy);
    bit          pushd = 0;
    bit          pop;
    bit          full;
    logic [31:0] w = 0;
    pop  = (mq.size() != 0) && rdy;
    full = (mq.size() == DEPTH);
    if (sv) begin
      if (bf) begin
        if (ms_held) begin w = w_sig1(ms); pushd = 1; ms_held = 0; end
        mb.push_back(32'(din[5:0]));
        if (mb.size() == 5) begin w = w_base5(mb); pushd = 1; mb.delete(); end
      end else if (ms_held) begin
        w = w_sig2(32'(din), ms); pushd = 1; ms_held = 0;
      end else begin
        if (mb.size() > 0) begin w = w_basep(mb); pushd = 1; mb.delete(); end
        ms = 32'(din); ms_held = 1;
      end
    end
    if ((fl || m_pend) && (ms_held || mb.size() > 0)) begin
      if (!pushd) begin
        w = ms_held ? w_sig1(ms) : w_basep(mb);
        pushd = 1; ms_held = 0; mb.delete(); m_pend = 0;
      end else begin
        m_pend = 1;
      end
    end else begin
      m_pend = 0;
    end
`ifdef LDTU_PACKER_FRAME_EN
    if (pushd) begin
      m_dcnt++;
      if (m_dcnt == FL) begin m_dcnt = 0; m_tpend = 1; end
    end else if (m_tpend) begin
      w = w_trail(32'(m_fcnt)); pushd = 1; m_tpend = 0; m_fcnt = (m_fcnt + 1) % 256;
    end
`endif
    if (pop) void'(mq.pop_front());
    if (pushd) begin
      if (full && !pop) m_ovf = 1;
      else mq.push_back(w);
    end
  endtask

  // Drive one cycle of inputs; outputs are then stable at the falling edge.
  task automatic step(input bit sv, input logic [12:0] din, input bit bf,
                      input bit fl, input bit rdy);
    sample_valid = sv; DATA_in = din; baseline_flag = bf; flush = fl; word_ready = rdy;
    if (use_model) model_cycle(sv, din, bf, fl, rdy);
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    sample_valid = 0; DATA_in = 0; baseline_flag = 0; flush = 0; word_ready = 0;
    @(negedge CLK);
    rst_b = 0;
    model_clear();
    repeat (2) @(negedge CLK);
    chk("rst_valid", 32'(word_valid), 32'h0);
    chk("rst_data",  word_data,       32'h0);
    chk("rst_ovf",   32'(fifo_ovf),   32'h0);
    rst_b = 1;
    @(negedge CLK);
  endtask

  typedef struct {
    logic        sv;
    logic [12:0] din;
    logic        bf;
    logic        fl;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
  } vec_t;

  vec_t        tbl[19];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [31:0] bq[$];
  logic [31:0] prev;

  initial begin
    //          sv din      bf fl rdy  ev  ed
    tbl[0]  = '{1, 13'h1A41, 1, 0, 0,  0, 32'h0};        // only [5:0]=01 used
    tbl[1]  = '{1, 13'h0002, 1, 0, 0,  0, 32'h0};
    tbl[2]  = '{1, 13'h0003, 1, 0, 0,  0, 32'h0};
    tbl[3]  = '{1, 13'h0004, 1, 0, 0,  0, 32'h0};
    tbl[4]  = '{1, 13'h0005, 1, 0, 0,  1, 32'h4510_3081}; // BASE5 01..05
    tbl[5]  = '{0, 13'h0000, 0, 0, 1,  0, 32'h0};
    tbl[6]  = '{1, 13'h1ABC, 0, 0, 0,  0, 32'h0};
    tbl[7]  = '{1, 13'h0123, 0, 0, 0,  1, 32'h2024_7ABC}; // SIG2
    tbl[8]  = '{1, 13'h003F, 1, 1, 1,  1, 32'hE100_003F}; // BASEP cnt=1
    tbl[9]  = '{0, 13'h0000, 0, 0, 0,  1, 32'hE100_003F};
    tbl[10] = '{0, 13'h0000, 0, 0, 1,  0, 32'h0};
    tbl[11] = '{0, 13'h0000, 0, 1, 1,  0, 32'h0};        // flush with nothing held
    tbl[12] = '{1, 13'h0FFF, 0, 1, 0,  1, 32'h3000_0FFF}; // SIG1 via flush
    tbl[13] = '{1, 13'h002A, 1, 0, 1,  0, 32'h0};
    tbl[14] = '{1, 13'h0015, 1, 1, 0,  1, 32'hE200_056A}; // BASEP cnt=2
    tbl[15] = '{1, 13'h1000, 0, 0, 1,  0, 32'h0};
    tbl[16] = '{1, 13'h0007, 1, 1, 0,  1, 32'h3000_1000}; // SIG1, flush deferred
    tbl[17] = '{0, 13'h0000, 0, 0, 1,  1, 32'hE100_0007}; // deferred flush
    tbl[18] = '{0, 13'h0000, 0, 0, 1,  0, 32'h0};

    do_reset();

`ifndef LDTU_PACKER_FRAME_EN
    // ---- table-driven vectors ----
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].sv, tbl[i].din, tbl[i].bf, tbl[i].fl, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), 32'(word_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_data", i),  word_data,       tbl[i].ed);
    end
    chk("tbl_ovf", 32'(fifo_ovf), 32'h0);

    // ---- alternating baseline/signal, one word per cycle ----
    do_reset();
    prev = 0;
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) begin
        step(1, 13'(k + 1), 1, 0, 1);
        if (k != 0) begin
          chk($sformatf("alt%0d_valid", k), 32'(word_valid), 32'h1);
          chk($sformatf("alt%0d_data", k),  word_data,       w_sig1(prev));
        end
        prev = 32'(k + 1);
      end else begin
        step(1, 13'h1000 + 13'(k), 0, 0, 1);
        chk($sformatf("alt%0d_valid", k), 32'(word_valid), 32'h1);
        chk($sformatf("alt%0d_data", k),  word_data,       32'hE100_0000 | prev);
        prev = 32'h1000 + 32'(k);
      end
    end
    chk("alt_ovf", 32'(fifo_ovf), 32'h0);

    // ---- overflow: 6 pushes into a depth-4 FIFO with word_ready low ----
    do_reset();
    for (int k = 0; k < 12; k++) begin
      step(1, 13'h0100 + 13'(k), 0, 0, 0);
      if (k % 2 == 1)
        chk($sformatf("ovf_after_push%0d", k / 2 + 1), 32'(fifo_ovf), 32'((k / 2) >= 4));
    end
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("drain%0d_valid", j), 32'(word_valid), 32'h1);
      chk($sformatf("drain%0d_data", j),  word_data,
          w_sig2(32'h0100 + 32'(2 * j + 1), 32'h0100 + 32'(2 * j)));
      step(0, 0, 0, 0, 1);
    end
    chk("drain_empty", 32'(word_valid), 32'h0);
    chk("ovf_sticky",  32'(fifo_ovf),   32'h1);
    do_reset();
`else
    // ---- frame trailers with FrameLen=2 ----
    got_q.delete();
    for (int k = 0; k < 11; k++) begin
      if (k == 4 || k >= 9) step(0, 0, 0, 0, 1);
      else step(1, 13'h0200 + 13'(k), 0, 0, 1);
      if (word_valid) got_q.push_back(word_data);
    end
    exp_q = '{w_sig2(32'h201, 32'h200), w_sig2(32'h203, 32'h202), w_trail(0),
              w_sig2(32'h206, 32'h205), w_sig2(32'h208, 32'h207), w_trail(1)};
    chk("frame_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("frame_word%0d", i), got_q[i], exp_q[i]);
    do_reset();
`endif

    // ---- asynchronous reset while three baselines are held ----
    step(1, 13'h0AAA, 0, 0, 0);
    step(1, 13'h0555, 0, 0, 0);
    step(1, 13'h0011, 1, 0, 0);
    step(1, 13'h0012, 1, 0, 0);
    step(1, 13'h0013, 1, 0, 0);
    chk("pre_async_valid", 32'(word_valid), 32'h1);
    #2 rst_b = 0;
    #1;
    chk("async_valid", 32'(word_valid), 32'h0);
    chk("async_data",  word_data,       32'h0);
    #1 rst_b = 1;
    bq.delete();
    for (int k = 0; k < 5; k++) begin
      step(1, 13'h0031 + 13'(k), 1, 0, 0);
      bq.push_back(32'h31 + 32'(k));
    end
    chk("post_async_valid", 32'(word_valid), 32'h1);
    chk("post_async_base5", word_data,       w_base5(bq));

    // ---- randomized stimulus against the reference model ----
    do_reset();
    use_model = 1;
    for (int c = 0; c < 1500; c++) begin
      bit          sv, bf, fl, rdy;
      logic [12:0] din;
      sv  = ($urandom_range(0, 3) != 0);
      bf  = $urandom_range(0, 1) == 1;
      fl  = ($urandom_range(0, 9) == 0);
      din = 13'($urandom);
      rdy = (c < 1000) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
      step(sv, din, bf, fl, rdy);
      chk($sformatf("rnd%0d_valid", c), 32'(word_valid), 32'(mq.size() != 0));
      chk($sformatf("rnd%0d_data", c),  word_data, (mq.size() != 0) ? mq[0] : 32'h0);
      chk($sformatf("rnd%0d_ovf", c),   32'(fifo_ovf), 32'(m_ovf));
    end
    use_model = 0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
